// File: rtl/inverter_bist.sv
// inverter_bist: built-in self-test engine for an N-channel inverter array.
// It applies a fixed vector sequence (all-zeros, all-ones, then a walking one)
// to the inverters, waits a programmable settle time after each vector, and
// compares the returned outputs against ~A. Mismatching bits are counted in a
// saturating counter and recorded in a sticky per-channel mask.
//
// Optional build macro: INVERTER_BIST_SYNC_EN
//   defined   - Q goes through a two-flop synchroniser before comparison and
//               each vector occupies SETTLE+3 cycles
//   undefined - Q is compared directly and each vector occupies SETTLE+1 cycles
//
// Ports:
//   Clock     in   system clock, rising edge
//   nReset    in   asynchronous active-low reset
//   Start     in   begin a test run (sampled only in IDLE)
//   A         out  [WIDTH] stimulus to the inverter inputs
//   Q         in   [WIDTH] inverter outputs
//   Busy      out  run in progress
//   Done      out  one-cycle pulse at the end of a run
//   Pass      out  last run had no mismatches (valid from Done to next Start)
//   ErrCount  out  [ERRW] saturating count of mismatching bits
//   ErrMask   out  [WIDTH] sticky per-channel mismatch flags
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | A=0, results held, waiting for Start
// S_SETTLE | vector k on A, counting settle cycles
// S_CHECK  | compare Q against ~A, accumulate errors, advance vector
// S_DONE   | Done pulse, Pass updated, return to idle

module inverter_bist #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 4,
  parameter int ERRW   = 8
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             Start,
  output logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] Q,
  output logic             Busy,
  output logic             Done,
  output logic             Pass,
  output logic [ERRW-1:0]  ErrCount,
  output logic [WIDTH-1:0] ErrMask
);

  localparam int V  = WIDTH + 2;
  localparam int KW = $clog2(V);
  localparam int CW = $clog2(SETTLE + 2) + 1;
  // Sum width leaves headroom for ErrCount plus a popcount of up to 16 bits.
  localparam int SW = ((ERRW > 5) ? ERRW : 5) + 1;

`ifdef INVERTER_BIST_SYNC_EN
  localparam int SETTLE_LAST = SETTLE + 1;
`else
  localparam int SETTLE_LAST = SETTLE - 1;
`endif

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

  state_t          state;
  logic [KW-1:0]   k;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] q_cmp;
  logic [WIDTH-1:0] diff;
  logic [SW-1:0]   pop;
  logic [SW-1:0]   sum;
  logic [ERRW-1:0] new_cnt;

`ifdef INVERTER_BIST_SYNC_EN
  logic [WIDTH-1:0] q_s1;
  logic [WIDTH-1:0] q_s2;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      q_s1 <= '0;
      q_s2 <= '0;
    end else begin
      q_s1 <= Q;
      q_s2 <= q_s1;
    end
  end

  assign q_cmp = q_s2;
`else
  assign q_cmp = Q;
`endif

  function automatic logic [WIDTH-1:0] vec_of(input logic [KW-1:0] idx);
    logic [WIDTH-1:0] v;
    v = '0;
    if (idx == KW'(1)) begin
      v = '1;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        v[i] = (int'(idx) == i + 2);
      end
    end
    return v;
  endfunction

  // Mismatch accounting; only consumed in S_CHECK, so Q is irrelevant elsewhere.
  always_comb begin
    diff = q_cmp ^ ~A;
    pop  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + SW'(diff[i]);
    end
    sum = SW'(ErrCount) + pop;
    if (sum > SW'({ERRW{1'b1}})) begin
      new_cnt = '1;
    end else begin
      new_cnt = sum[ERRW-1:0];
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state    <= S_IDLE;
      A        <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Pass     <= 1'b0;
      ErrCount <= '0;
      ErrMask  <= '0;
      k        <= '0;
      cnt      <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        S_IDLE: begin
          A    <= '0;
          Busy <= 1'b0;
          if (Start) begin
            ErrCount <= '0;
            ErrMask  <= '0;
            Pass     <= 1'b0;
            k        <= '0;
            A        <= vec_of('0);
            cnt      <= '0;
            Busy     <= 1'b1;
            state    <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (cnt == CW'(SETTLE_LAST)) begin
            state <= S_CHECK;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_CHECK: begin
          ErrCount <= new_cnt;
          ErrMask  <= ErrMask | diff;
          if (k == KW'(V - 1)) begin
            // Outputs for the DONE cycle are registered on this edge.
            Busy  <= 1'b0;
            Done  <= 1'b1;
            Pass  <= (new_cnt == '0);
            A     <= '0;
            state <= S_DONE;
          end else begin
            k     <= k + KW'(1);
            A     <= vec_of(k + KW'(1));
            cnt   <= '0;
            state <= S_SETTLE;
          end
        end
        S_DONE: begin
          k     <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inverter_bist.sv
module tb_inverter_bist;

  localparam int WIDTH = 4;
  localparam int SETTLE = 4;
`ifdef INVERTER_BIST_SYNC_EN
  localparam int STEP = SETTLE + 3;
`else
  localparam int STEP = SETTLE + 1;
`endif
  localparam int RUN = 6 * STEP;

  logic             Clock = 1'b0;
  logic             nReset;
  logic             Start;
  logic [WIDTH-1:0] A, Q;
  logic             Busy, Done, Pass;
  logic [7:0]       ErrCount;
  logic [WIDTH-1:0] ErrMask;

  logic [WIDTH-1:0] a4, q4;
  logic             busy4, done4, pass4;
  logic [3:0]       err4;
  logic [WIDTH-1:0] mask4;

  int checks = 0;
  int errors = 0;
  int mode = 0;

  logic [WIDTH-1:0] a_seen [6];
  int   busy_lows;
  logic done_busy;

  always #5 Clock = ~Clock;

  // Modelled inverter array: one cycle of delay, optional channel-2 stuck-at-0.
  always @(posedge Clock) begin
    if (mode == 1) Q <= ~A & 4'b1011;
    else           Q <= ~A;
    q4 <= a4;  // buffer, every bit wrong
  end

  inverter_bist #(.WIDTH(WIDTH), .SETTLE(SETTLE), .ERRW(8)) dut (
    .Clock(Clock), .nReset(nReset), .Start(Start), .A(A), .Q(Q),
    .Busy(Busy), .Done(Done), .Pass(Pass), .ErrCount(ErrCount), .ErrMask(ErrMask)
  );

  inverter_bist #(.WIDTH(WIDTH), .SETTLE(SETTLE), .ERRW(4)) dut4 (
    .Clock(Clock), .nReset(nReset), .Start(Start), .A(a4), .Q(q4),
    .Busy(busy4), .Done(done4), .Pass(pass4), .ErrCount(err4), .ErrMask(mask4)
  );

  // Pulses Start for one cycle and follows the run until Done; returns the
  // number of cycles from Busy rising to Done, or -1 on timeout.
  task automatic run_once(output int len);
    @(negedge Clock) Start = 1'b1;
    @(negedge Clock) Start = 1'b0;
    len = -1;
    busy_lows = 0;
    done_busy = 1'b1;
    for (int n = 0; n < 200; n++) begin
      if ((n % STEP) == 0 && (n / STEP) < 6) a_seen[n / STEP] = A;
      if (Done) begin
        len = n;
        done_busy = Busy;
        break;
      end
      if (!Busy) busy_lows++;
      @(negedge Clock);
    end
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    Start = 1'b0;
    #2;
    checks++;
    if ({A, Busy, Done, Pass, ErrCount, ErrMask} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got A=%b Busy=%b Done=%b Pass=%b Err=%0d Mask=%b want all 0",
               A, Busy, Done, Pass, ErrCount, ErrMask);
    end
    repeat (2) @(negedge Clock);
    nReset = 1'b1;
    repeat (2) @(negedge Clock);
    checks++;
    if (Busy !== 1'b0 || A !== 4'b0000) begin
      errors++;
      $display("FAIL idle_after_reset got Busy=%b A=%b want 0 0000", Busy, A);
    end
  endtask

  task automatic test_good();
    logic [WIDTH-1:0] exp_a [6];
    int len;
    exp_a = '{4'b0000, 4'b1111, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    mode = 0;
    run_once(len);
    checks++;
    if (len !== RUN) begin
      errors++;
      $display("FAIL good_len got %0d want %0d", len, RUN);
    end
    checks++;
    if (busy_lows !== 0 || done_busy !== 1'b0) begin
      errors++;
      $display("FAIL good_busy got lows=%0d busy_at_done=%b want 0 0", busy_lows, done_busy);
    end
    for (int j = 0; j < 6; j++) begin
      checks++;
      if (a_seen[j] !== exp_a[j]) begin
        errors++;
        $display("FAIL good_vec%0d got %b want %b", j, a_seen[j], exp_a[j]);
      end
    end
    checks++;
    if (Pass !== 1'b1 || ErrCount !== 8'd0 || ErrMask !== 4'b0000 || A !== 4'b0000) begin
      errors++;
      $display("FAIL good_result got Pass=%b Err=%0d Mask=%b A=%b want 1 0 0000 0000",
               Pass, ErrCount, ErrMask, A);
    end
    @(negedge Clock);
    checks++;
    if (Done !== 1'b0) begin
      errors++;
      $display("FAIL good_done_pulse got Done=%b want 0", Done);
    end
    repeat (3) @(negedge Clock);
    checks++;
    if (Pass !== 1'b1 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL good_hold got Pass=%b Busy=%b want 1 0", Pass, Busy);
    end
  endtask

  task automatic test_stuck();
    int len;
    mode = 1;
    run_once(len);
    checks++;
    if (len !== RUN) begin
      errors++;
      $display("FAIL stuck_len got %0d want %0d", len, RUN);
    end
    checks++;
    if (ErrCount !== 8'd4 || ErrMask !== 4'b0100 || Pass !== 1'b0) begin
      errors++;
      $display("FAIL stuck_result got Err=%0d Mask=%b Pass=%b want 4 0100 0",
               ErrCount, ErrMask, Pass);
    end
    repeat (3) @(negedge Clock);
    checks++;
    if (ErrCount !== 8'd4 || ErrMask !== 4'b0100) begin
      errors++;
      $display("FAIL stuck_hold got Err=%0d Mask=%b want 4 0100", ErrCount, ErrMask);
    end
    mode = 0;
  endtask

  task automatic test_saturate();
    int len;
    run_once(len);
    checks++;
    if (done4 !== 1'b1 || err4 !== 4'd15 || mask4 !== 4'b1111 || pass4 !== 1'b0) begin
      errors++;
      $display("FAIL saturate got Done=%b Err=%0d Mask=%b Pass=%b want 1 15 1111 0",
               done4, err4, mask4, pass4);
    end
  endtask

  task automatic test_start_held();
    int dones;
    int n2;
    mode = 1;
    dones = 0;
    @(negedge Clock) Start = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge Clock);
      if (Done) dones++;
      if (n == RUN) begin
        checks++;
        if (Done !== 1'b1 || ErrCount !== 8'd4) begin
          errors++;
          $display("FAIL held_first_done got Done=%b Err=%0d want 1 4", Done, ErrCount);
        end
      end
      if (n == RUN + 1) begin
        checks++;
        if (Busy !== 1'b0 || ErrCount !== 8'd4) begin
          errors++;
          $display("FAIL held_idle_gap got Busy=%b Err=%0d want 0 4", Busy, ErrCount);
        end
      end
      if (n == RUN + 2) begin
        checks++;
        if (Busy !== 1'b1 || ErrCount !== 8'd0 || ErrMask !== 4'b0000 || Pass !== 1'b0) begin
          errors++;
          $display("FAIL held_restart got Busy=%b Err=%0d Mask=%b Pass=%b want 1 0 0000 0",
                   Busy, ErrCount, ErrMask, Pass);
        end
      end
    end
    Start = 1'b0;
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL held_done_count got %0d want 1", dones);
    end
    n2 = 0;
    while (!Done && n2 < 200) begin
      @(negedge Clock);
      n2++;
    end
    checks++;
    if (Done !== 1'b1) begin
      errors++;
      $display("FAIL held_second_run got no Done within %0d cycles", n2);
    end
    repeat (2) @(negedge Clock);
    mode = 0;
  endtask

  task automatic test_reset_mid_run();
    int len;
    int dones;
    mode = 0;
    @(negedge Clock) Start = 1'b1;
    @(negedge Clock) Start = 1'b0;
    repeat (12) @(negedge Clock);
    nReset = 1'b0;
    #1;
    checks++;
    if ({A, Busy, Done, Pass, ErrCount, ErrMask} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got A=%b Busy=%b Done=%b Pass=%b Err=%0d Mask=%b want all 0",
               A, Busy, Done, Pass, ErrCount, ErrMask);
    end
    dones = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge Clock);
      if (Done || Busy) dones++;
    end
    nReset = 1'b1;
    for (int n = 0; n < RUN + 4; n++) begin
      @(negedge Clock);
      if (Done || Busy) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL midreset_no_done got %0d active cycles want 0", dones);
    end
    run_once(len);
    checks++;
    if (len !== RUN || Pass !== 1'b1 || ErrCount !== 8'd0) begin
      errors++;
      $display("FAIL midreset_rerun got len=%0d Pass=%b Err=%0d want %0d 1 0",
               len, Pass, ErrCount, RUN);
    end
  endtask

  initial begin
    Start = 1'b0;
    nReset = 1'b0;
    test_reset();
    test_good();
    test_stuck();
    test_saturate();
    test_start_held();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
